// File: rtl/imem_axil_responder.sv
// AXI4-Lite read-only instruction memory with a 2-entry response queue; IMEM_ADDR_CHECK_EN adds SLVERR on bad addresses.
// One-cycle AR->R latency, full AR throughput; arready (registered) drops only when the queue is full.
module imem_axil_responder #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_im_arvalid,
  output logic                     o_im_arready,
  input  logic [ADDR_WIDTH-1:0]    i_im_araddr,
  input  logic [2:0]               i_im_arprot,
  output logic                     o_im_rvalid,
  input  logic                     i_im_rready,
  output logic [XLEN-1:0]          o_im_rdata,
  output logic [1:0]               o_im_rresp,
  input  logic                     i_ld_en,
  input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
  input  logic [XLEN-1:0]          i_ld_data
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [XLEN-1:0]  q_dat_q [2];
  logic [1:0]       q_rsp_q [2];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       count_q, count_d;
  logic             arready_q, arready_d;
  logic             push, pop;
  logic [IDX_W-1:0] rd_idx;
  logic [XLEN-1:0]  ent_dat;
  logic [1:0]       ent_rsp;
  logic             unused_bits;

  assign rd_idx = i_im_araddr[IDX_W+1:2];

`ifdef IMEM_ADDR_CHECK_EN
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(DEPTH) << 2;
  localparam logic [XLEN-1:0]     NOP_INSN   = XLEN'(32'h0000_0013);
  logic addr_err;

  // Bad fetches still occupy a queue slot so ordering is preserved.
  assign addr_err    = (i_im_araddr[1:0] != 2'b00) || ({1'b0, i_im_araddr} >= ADDR_LIMIT);
  assign ent_dat     = addr_err ? NOP_INSN : mem[rd_idx];
  assign ent_rsp     = addr_err ? 2'b10 : 2'b00;
  assign unused_bits = ^i_im_arprot;
`else
  assign ent_dat     = mem[rd_idx];
  assign ent_rsp     = 2'b00;
  assign unused_bits = ^{i_im_arprot, i_im_araddr[1:0], i_im_araddr[ADDR_WIDTH-1:IDX_W+2]};
`endif

  // Program load port; no reset so contents survive a control-path reset.
  always_ff @(posedge clk) begin
    if (i_ld_en) begin
      mem[i_ld_addr] <= i_ld_data;
    end
  end

  always_comb begin
    push      = i_im_arvalid & arready_q;
    pop       = (count_q != 2'd0) & i_im_rready;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    if (push) wptr_d = ~wptr_q;
    if (pop)  rptr_d = ~rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    arready_d = (count_d < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      count_q   <= 2'd0;
      arready_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_dat_q[i] <= '0;
        q_rsp_q[i] <= 2'b00;
      end
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      arready_q <= arready_d;
      // Read and load share an edge: the queue captures the pre-load word.
      if (push) begin
        q_dat_q[wptr_q] <= ent_dat;
        q_rsp_q[wptr_q] <= ent_rsp;
      end
    end
  end

  assign o_im_arready = arready_q;
  assign o_im_rvalid  = (count_q != 2'd0);
  assign o_im_rdata   = q_dat_q[rptr_q];
  assign o_im_rresp   = q_rsp_q[rptr_q];

endmodule

// File: tb/tb_imem_axil_responder.sv
// Bench for imem_axil_responder: queue-level model checked every cycle plus literal expectations per scenario.
module tb_imem_axil_responder;
  localparam int XLEN  = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             i_im_arvalid;
  logic             o_im_arready;
  logic [AW-1:0]    i_im_araddr;
  logic [2:0]       i_im_arprot;
  logic             o_im_rvalid;
  logic             i_im_rready;
  logic [XLEN-1:0]  o_im_rdata;
  logic [1:0]       o_im_rresp;
  logic             i_ld_en;
  logic [IDX_W-1:0] i_ld_addr;
  logic [XLEN-1:0]  i_ld_data;

  int total = 0;
  int bad   = 0;

  rsp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  logic        m_arready = 1'b0;
  logic        m_live    = 1'b0;
  logic [31:0] got_d[$];
  logic [1:0]  got_r[$];
  logic [31:0] lit_d[$];
  logic [1:0]  lit_r[$];

  imem_axil_responder #(.XLEN(XLEN), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_im_arvalid (i_im_arvalid),
    .o_im_arready (o_im_arready),
    .i_im_araddr  (i_im_araddr),
    .i_im_arprot  (i_im_arprot),
    .o_im_rvalid  (o_im_rvalid),
    .i_im_rready  (i_im_rready),
    .o_im_rdata   (o_im_rdata),
    .o_im_rresp   (o_im_rresp),
    .i_ld_en      (i_ld_en),
    .i_ld_addr    (i_ld_addr),
    .i_ld_data    (i_ld_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rsp_t predict(input logic [31:0] a);
    rsp_t r;
`ifdef IMEM_ADDR_CHECK_EN
    if ((a % 4) != 0 || a >= 4 * DEPTH) begin
      r.d = 32'h0000_0013;
      r.r = 2'b10;
    end else begin
      r.d = mem_m[a / 4];
      r.r = 2'b00;
    end
`else
    r.d = mem_m[(a / 4) % DEPTH];
    r.r = 2'b00;
`endif
    return r;
  endfunction

  // Model: an ordered list of pending responses; AR is accepted whenever fewer than two are pending.
  always @(posedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      m_arready = 1'b0;
      m_live    = 1'b1;
    end else begin
      if (exp_q.size() != 0 && i_im_rready) void'(exp_q.pop_front());
      if (i_im_arvalid && m_arready) exp_q.push_back(predict(i_im_araddr));
      if (i_ld_en) mem_m[i_ld_addr] = i_ld_data;
      m_arready = (exp_q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("arready", 64'(o_im_arready), 64'(m_arready));
      check("rvalid", 64'(o_im_rvalid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("rdata", 64'(o_im_rdata), 64'(exp_q[0].d));
        check("rresp", 64'(o_im_rresp), 64'(exp_q[0].r));
      end
      if (o_im_rvalid && i_im_rready) begin
        got_d.push_back(o_im_rdata);
        got_r.push_back(o_im_rresp);
      end
    end
  end

  task automatic do_ar(input logic [31:0] a);
    bit done = 1'b0;
    bit rdy;
    i_im_arvalid = 1'b1;
    i_im_araddr  = a;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      rdy = o_im_arready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    check("ar_accept", 64'(done), 64'd1);
    i_im_arvalid = 1'b0;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    i_ld_en   = 1'b1;
    i_ld_addr = IDX_W'(idx);
    i_ld_data = d;
    @(posedge clk);
    #1;
    i_ld_en = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_got(input string nm, input bit with_resp);
    check({nm, "_count"}, 64'(got_d.size()), 64'(lit_d.size()));
    for (int i = 0; i < lit_d.size(); i++) begin
      check({nm, "_data"}, (i < got_d.size()) ? 64'(got_d[i]) : 64'hx, 64'(lit_d[i]));
      if (with_resp)
        check({nm, "_resp"}, (i < got_r.size()) ? 64'(got_r[i]) : 64'hx, 64'(lit_r[i]));
    end
    got_d.delete();
    got_r.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    i_im_arvalid = 1'b0;
    i_im_araddr  = '0;
    i_im_arprot  = 3'b100;
    i_im_rready  = 1'b0;
    i_ld_en      = 1'b0;
    i_ld_addr    = '0;
    i_ld_data    = '0;
    cycles(3);

    @(negedge clk);
    check("rst_arready", 64'(o_im_arready), 64'd0);
    check("rst_rvalid", 64'(o_im_rvalid), 64'd0);
    check("rst_rdata", 64'(o_im_rdata), 64'd0);
    check("rst_rresp", 64'(o_im_rresp), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cycles(1);
    @(negedge clk);
    check("arready_after_reset", 64'(o_im_arready), 64'd1);
    @(posedge clk);
    #1;

    load(0, 32'h11);
    load(1, 32'h22);
    load(2, 32'h33);
    load(3, 32'h44);
    load(5, 32'h55);
    load(1023, 32'hCAFE_F00D);

    // Streaming with rready held high.
    i_im_rready = 1'b1;
    do_ar(32'h0);
    do_ar(32'h4);
    do_ar(32'h8);
    do_ar(32'hC);
    cycles(3);
    lit_d = '{32'h11, 32'h22, 32'h33, 32'h44};
    check_got("stream", 1'b0);

    // Backpressure: queue fills at two, third AR stalls.
    i_im_rready = 1'b0;
    do_ar(32'h0);
    do_ar(32'h4);
    fork
      do_ar(32'h8);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_arready", 64'(o_im_arready), 64'd0);
          check("bp_rvalid", 64'(o_im_rvalid), 64'd1);
          check("bp_rdata", 64'(o_im_rdata), 64'h11);
        end
        @(posedge clk);
        #1;
        i_im_rready = 1'b1;
      end
    join
    cycles(4);
    lit_d = '{32'h11, 32'h22, 32'h33};
    check_got("backpressure", 1'b0);

    // Load and fetch of the same word on the same edge.
    i_ld_en   = 1'b1;
    i_ld_addr = IDX_W'(5);
    i_ld_data = 32'hDEAD_BEEF;
    do_ar(32'h14);
    i_ld_en = 1'b0;
    do_ar(32'h14);
    cycles(3);
    lit_d = '{32'h55, 32'hDEAD_BEEF};
    check_got("rbw", 1'b0);

    // Reset with a full queue.
    i_im_rready = 1'b0;
    do_ar(32'h0);
    do_ar(32'h4);
    rstn = 1'b0;
    cycles(1);
    @(negedge clk);
    check("midrst_rvalid", 64'(o_im_rvalid), 64'd0);
    check("midrst_rdata", 64'(o_im_rdata), 64'd0);
    check("midrst_arready", 64'(o_im_arready), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    i_im_rready = 1'b1;
    cycles(1);
    @(negedge clk);
    check("postrst_arready", 64'(o_im_arready), 64'd1);
    cycles(5);
    lit_d.delete();
    check_got("no_stale", 1'b0);

    // Address handling at and beyond the top of memory.
`ifdef IMEM_ADDR_CHECK_EN
    do_ar(32'h1002);
    do_ar(32'h1000);
    do_ar(32'hFFC);
    cycles(3);
    lit_d = '{32'h13, 32'h13, 32'hCAFE_F00D};
    lit_r = '{2'b10, 2'b10, 2'b00};
`else
    do_ar(32'h1004);
    do_ar(32'h1002);
    do_ar(32'hFFC);
    cycles(3);
    lit_d = '{32'h22, 32'h11, 32'hCAFE_F00D};
    lit_r = '{2'b00, 2'b00, 2'b00};
`endif
    check_got("addr", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
